// File: rtl/ccsds123_sa_encoder.sv
// ccsds123_sa_encoder
//   Sample-adaptive Golomb-power-of-2 entropy coder for CCSDS-123 mapped
//   residuals arriving in BIP order (z fastest, then x, then y).
//   One per-band accumulator sigma[z] and one shared counter gamma.
//   Two-stage pipeline: stage 1 picks k and adapts state, stage 2 forms the
//   length-prefixed codeword. Fixed 2-cycle latency, no backpressure.
// Ports:
//   clk, aresetn        clock, async active-low reset
//   res, res_valid      mapped residual input, accepted every valid cycle
//   cw_bits, cw_len     right-aligned codeword, MSB (bit cw_len-1) sent first
//   cw_valid, cw_last   codeword strobe; cw_last marks the image's final sample
module ccsds123_sa_encoder #(
  parameter int NX         = 4,
  parameter int NY         = 4,
  parameter int NZ         = 16,
  parameter int D          = 16,
  parameter int UMAX       = 18,
  parameter int GAMMA0     = 1,
  parameter int GAMMA_STAR = 5,
  parameter int KZ         = 3
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [D-1:0]       res,
  input  logic               res_valid,
  output logic [UMAX+D-1:0]  cw_bits,
  output logic [6:0]         cw_len,
  output logic               cw_valid,
  output logic               cw_last
);

  localparam int NPIX   = NX * NY;
  localparam int CW     = UMAX + D;
  localparam int SW     = D + GAMMA_STAR;
  localparam int GW     = GAMMA_STAR + 1;
  localparam int ZW     = (NZ > 1) ? $clog2(NZ) : 1;
  localparam int TW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int KW     = $clog2(D);
  localparam int STAGES = 2;

  localparam logic [SW-1:0] SIGMA_INIT = SW'(((3 * (1 << (KZ + 6)) - 49) * (1 << GAMMA0)) / 128);
  localparam logic [GW-1:0] GAMMA_INIT = GW'(1 << GAMMA0);
  localparam logic [GW-1:0] GAMMA_MAX  = GW'((1 << GAMMA_STAR) - 1);

  typedef struct packed {
    logic [D-1:0]  delta;
    logic [KW-1:0] k;
    logic          first;
    logic          last;
  } s1_t;

  logic [ZW-1:0]           z;
  logic [TW-1:0]           t;
  logic [GW-1:0]           gamma;
  logic [NZ-1:0][SW-1:0]   sigma;
  s1_t                     s1;
  logic [STAGES:1]         vld_pipe;

  logic                    z_end, last_smp;
  logic [SW-1:0]           sig_rd, sig_nx;
  logic [SW:0]             t_sum, acc;
  logic [GW+5:0]           g49;
  logic [KW-1:0]           k_calc;

  assign z_end    = (z == ZW'(NZ - 1));
  assign last_smp = z_end && (t == TW'(NPIX - 1));

  // Stage 1 combinational: k selection and next accumulator value.
  always_comb begin
    sig_rd = sigma[z];
    g49    = (GW+6)'(gamma) * (GW+6)'(49);
    t_sum  = (SW+1)'(sig_rd) + (SW+1)'(g49 >> 7);
    // Gamma*2^k <= T is monotonic in k, so the last hit is the largest k;
    // when 2*Gamma > T no i>0 hits and k stays 0.
    k_calc = '0;
    for (int i = 0; i <= D - 2; i++)
      if (((SW+D)'(gamma) << i) <= (SW+D)'(t_sum)) k_calc = KW'(i);
    acc = (SW+1)'(sig_rd) + (SW+1)'(res);
    if (gamma < GAMMA_MAX) sig_nx = acc[SW-1:0];
    else                   sig_nx = SW'((acc + (SW+1)'(1)) >> 1);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      z        <= '0;
      t        <= '0;
      gamma    <= GAMMA_INIT;
      sigma    <= {NZ{SIGMA_INIT}};
      s1       <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], res_valid};
      if (res_valid) begin
        s1 <= '{delta: res, k: k_calc, first: (t == '0), last: last_smp};
        if (last_smp) begin
          // Image boundary: state returns to its reset values.
          z     <= '0;
          t     <= '0;
          gamma <= GAMMA_INIT;
          sigma <= {NZ{SIGMA_INIT}};
        end else begin
          // First pixel is raw-coded and does not train the statistics.
          if (t != '0) begin
            sigma[z] <= sig_nx;
            if (z_end)
              gamma <= (gamma < GAMMA_MAX) ? gamma + GW'(1) : (gamma + GW'(1)) >> 1;
          end
          if (z_end) begin
            z <= '0;
            t <= t + TW'(1);
          end else begin
            z <= z + ZW'(1);
          end
        end
      end
    end
  end

  // Stage 2 combinational: codeword formation.
  logic [D-1:0]  u, lsb_mask;
  logic [CW-1:0] bits_nx;
  logic [6:0]    len_nx;

  always_comb begin
    u        = s1.delta >> s1.k;
    lsb_mask = (D'(1) << s1.k) - D'(1);
    if (s1.first) begin
      bits_nx = CW'(s1.delta);
      len_nx  = 7'(D);
    end else if (32'(u) < 32'(UMAX)) begin
      // u zeros, a terminating 1, then k LSBs; leading zeros are implicit.
      bits_nx = (CW'(1) << s1.k) | CW'(s1.delta & lsb_mask);
      len_nx  = 7'(u) + 7'(s1.k) + 7'd1;
    end else begin
      // Escape: UMAX zeros then delta in D bits.
      bits_nx = CW'(s1.delta);
      len_nx  = 7'(CW);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cw_bits <= '0;
      cw_len  <= '0;
      cw_last <= 1'b0;
    end else if (vld_pipe[1]) begin
      cw_bits <= bits_nx;
      cw_len  <= len_nx;
      cw_last <= s1.last;
    end else begin
      cw_last <= 1'b0;
    end
  end

  assign cw_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_ccsds123_sa_encoder.sv
// Self-checking bench for ccsds123_sa_encoder. A sample-level model of the
// coder predicts every codeword and its due cycle; a single monitor compares
// DUT output against it at each negedge. An 8x4 image is used so the shared
// counter reaches its ceiling and rescales inside one image.
module tb_ccsds123_sa_encoder;
  localparam int NX = 8, NY = 4, NZ = 16, D = 16, UMAX = 18;
  localparam int GAMMA0 = 1, GAMMA_STAR = 5, KZ = 3;
  localparam int NPIX = NX * NY, NS = NPIX * NZ, CW = UMAX + D;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [D-1:0]  res = '0;
  logic          res_valid = 1'b0;
  logic [CW-1:0] cw_bits;
  logic [6:0]    cw_len;
  logic          cw_valid, cw_last;

  ccsds123_sa_encoder #(
    .NX(NX), .NY(NY), .NZ(NZ), .D(D), .UMAX(UMAX),
    .GAMMA0(GAMMA0), .GAMMA_STAR(GAMMA_STAR), .KZ(KZ)
  ) dut (
    .clk(clk), .aresetn(aresetn), .res(res), .res_valid(res_valid),
    .cw_bits(cw_bits), .cw_len(cw_len), .cw_valid(cw_valid), .cw_last(cw_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint bits;
    int     len;
    bit     last;
    int     stamp;
    int     idx;
  } exp_t;

  exp_t   expq[$];
  longint m_sig[NZ];
  longint m_gam;
  int     m_z, m_t;

  function automatic void model_reset();
    for (int i = 0; i < NZ; i++)
      m_sig[i] = ((3 * (2 ** (KZ + 6)) - 49) * (2 ** GAMMA0)) / 128;
    m_gam = 2 ** GAMMA0;
    m_z = 0;
    m_t = 0;
  endfunction

  function automatic void model_push(input longint d, input int stamp);
    exp_t   e;
    longint tt, u, p2k;
    int     k;
    bit     first, last;
    first = (m_t == 0);
    last  = (m_t == NPIX - 1) && (m_z == NZ - 1);
    tt = m_sig[m_z] + (49 * m_gam) / 128;
    k = 0;
    if (2 * m_gam <= tt)
      while (k < D - 2 && m_gam * (64'd1 << (k + 1)) <= tt) k++;
    p2k = 64'd1 << k;
    u = d / p2k;
    if (first) begin
      e.bits = d; e.len = D;
    end else if (u < UMAX) begin
      e.bits = p2k + (d % p2k); e.len = int'(u) + 1 + k;
    end else begin
      e.bits = d; e.len = UMAX + D;
    end
    e.last = last; e.stamp = stamp; e.idx = m_t * NZ + m_z;
    expq.push_back(e);
    if (last) begin
      model_reset();
    end else begin
      if (!first) begin
        if (m_gam < 2 ** GAMMA_STAR - 1) m_sig[m_z] = m_sig[m_z] + d;
        else                              m_sig[m_z] = (m_sig[m_z] + d + 1) / 2;
        if (m_z == NZ - 1)
          m_gam = (m_gam < 2 ** GAMMA_STAR - 1) ? m_gam + 1 : (m_gam + 1) / 2;
      end
      if (m_z == NZ - 1) begin m_z = 0; m_t++; end
      else m_z++;
    end
  endfunction

  // ---------------- compare process ----------------
  longint obs_bits[NS];
  int     obs_len[NS];
  int     last_cnt = 0, last_idx = -1;

  always @(negedge clk) begin
    if (aresetn) begin
      if (cw_valid) begin
        if (expq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_cw: cw_valid at cycle %0d, none expected", cyc);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("latency", cyc, e.stamp + 2);
          chk("cw_bits", longint'(cw_bits), e.bits);
          chk("cw_len", longint'(cw_len), e.len);
          chk("cw_last", longint'(cw_last), longint'(e.last));
          obs_bits[e.idx] = cw_bits;
          obs_len[e.idx]  = cw_len;
          if (cw_last) begin last_cnt++; last_idx = e.idx; end
        end
      end else if (expq.size() > 0 && cyc > expq[0].stamp + 2) begin
        n_tests++; n_fail++;
        $display("FAIL missing_cw: sample %0d due cycle %0d, none by %0d",
                 expq[0].idx, expq[0].stamp + 2, cyc);
        void'(expq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [D-1:0] img[NS];
  longint       ref_bits[NS];
  int           ref_len[NS];

  task automatic send(input logic [D-1:0] d);
    @(posedge clk); #1;
    res = d; res_valid = 1'b1;
    model_push(longint'(d), cyc);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    res_valid = 1'b0; res = D'($urandom);
  endtask

  task automatic send_img(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 4)) idle();
      send(img[i]);
    end
  endtask

  task automatic drain(input string name);
    idle();
    for (int i = 0; i < 10 && expq.size() != 0; i++) idle();
    idle();
    chk(name, expq.size(), 0);
  endtask

  task automatic rand_img();
    for (int i = 0; i < NS; i++)
      case ($urandom_range(0, 3))
        0:       img[i] = D'($urandom);
        1:       img[i] = D'($urandom_range(0, 400));
        default: img[i] = D'($urandom_range(0, 40));
      endcase
  endtask

  task automatic chk_reset_outs();
    chk("rst_cw_valid", longint'(cw_valid), 0);
    chk("rst_cw_len", longint'(cw_len), 0);
    chk("rst_cw_bits", longint'(cw_bits), 0);
    chk("rst_cw_last", longint'(cw_last), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs();
    aresetn = 1'b1;

    // Directed first image: raw pixel 0, then k=3 coding and an escape.
    rand_img();
    for (int i = 0; i < NZ; i++) img[i] = D'(16'h1234 + i);
    img[16] = 16'd5; img[17] = 16'd0; img[18] = 16'd200;
    send_img(NS, 1'b0);
    drain("drain_directed");
    chk("pix0_bits", obs_bits[0], 64'h1234);
    chk("pix0_len", obs_len[0], 16);
    chk("pix0_z15_bits", obs_bits[15], 64'h1243);
    chk("p1z0_bits", obs_bits[16], 13);
    chk("p1z0_len", obs_len[16], 4);
    chk("p1z1_bits", obs_bits[17], 8);
    chk("p1z1_len", obs_len[17], 4);
    chk("p1z2_esc_bits", obs_bits[18], 200);
    chk("p1z2_esc_len", obs_len[18], 34);

    // All-zero image: gamma climbs to its ceiling, rescales, k falls to 0.
    for (int i = 0; i < NS; i++) img[i] = '0;
    last_cnt = 0; last_idx = -1;
    send_img(NS, 1'b0);
    drain("drain_zero");
    chk("zero_last_bits", obs_bits[NS-1], 1);
    chk("zero_last_len", obs_len[NS-1], 1);
    chk("last_pulses", last_cnt, 1);
    chk("last_index", last_idx, NS - 1);

    // Random image, gapless then with ~2/3 idle cycles: identical codewords.
    rand_img();
    send_img(NS, 1'b0);
    drain("drain_gapless");
    for (int i = 0; i < NS; i++) begin ref_bits[i] = obs_bits[i]; ref_len[i] = obs_len[i]; end
    send_img(NS, 1'b1);
    drain("drain_gapped");
    mism = 0;
    for (int i = 0; i < NS; i++)
      if (obs_bits[i] != ref_bits[i] || obs_len[i] != ref_len[i]) mism++;
    chk("gapped_vs_gapless", mism, 0);

    // Reset after sample 37, then a full image and a back-to-back repeat.
    rand_img();
    send_img(37, 1'b1);
    @(posedge clk); #1;
    res_valid = 1'b0;
    aresetn = 1'b0;
    expq.delete();
    model_reset();
    @(negedge clk);
    chk_reset_outs();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    send_img(NS, 1'b1);
    drain("drain_after_reset");
    for (int i = 0; i < NS; i++) begin ref_bits[i] = obs_bits[i]; ref_len[i] = obs_len[i]; end
    send_img(NS, 1'b0);
    drain("drain_second_image");
    mism = 0;
    for (int i = 0; i < NS; i++)
      if (obs_bits[i] != ref_bits[i] || obs_len[i] != ref_len[i]) mism++;
    chk("second_image_repeat", mism, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
